// File: rtl/mig_ui_responder_pkg.sv
// mig_ui_pkg: shared types for the MIG UI responder.
// Command codes, command-queue entry layout, backpressure LFSR constants.
package mig_ui_pkg;

  typedef enum logic [2:0] {
    CMD_WRITE = 3'b000,
    CMD_READ  = 3'b001
  } mig_cmd_e;

  localparam int IDX_MAX_W = 16;

  typedef struct packed {
    logic [IDX_MAX_W-1:0] idx;
    mig_cmd_e             cmd;
  } cmd_entry_t;

  localparam logic [7:0] LFSR_SEED = 8'hA5;
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  function automatic logic is_legal(
    input logic [2:0] c
  );
    return (c == CMD_WRITE) || (c == CMD_READ);
  endfunction

endpackage

// File: rtl/mig_ui_responder_if.sv
// mig_ui_responder_if: MIG 7-series app_* user interface bundle.
// master = traffic initiator, slave = memory-controller side.
interface mig_ui_responder_if #(
  parameter int ADDR_WIDTH     = 28,
  parameter int APP_DATA_WIDTH = 128,
  parameter int MASK_WIDTH     = 16
);
  logic [ADDR_WIDTH-1:0]     app_addr;
  logic [2:0]                app_cmd;
  logic                      app_en;
  logic                      app_rdy;
  logic [APP_DATA_WIDTH-1:0] app_wdf_data;
  logic [MASK_WIDTH-1:0]     app_wdf_mask;
  logic                      app_wdf_wren;
  logic                      app_wdf_end;
  logic                      app_wdf_rdy;
  logic [APP_DATA_WIDTH-1:0] app_rd_data;
  logic                      app_rd_data_valid;
  logic                      app_rd_data_end;
  logic                      init_calib_complete;
  logic                      cmd_error;

  modport master (
    output app_addr, app_cmd, app_en,
    output app_wdf_data, app_wdf_mask,
    output app_wdf_wren, app_wdf_end,
    input  app_rdy, app_wdf_rdy,
    input  app_rd_data, app_rd_data_valid,
    input  app_rd_data_end,
    input  init_calib_complete, cmd_error
  );

  modport slave (
    input  app_addr, app_cmd, app_en,
    input  app_wdf_data, app_wdf_mask,
    input  app_wdf_wren, app_wdf_end,
    output app_rdy, app_wdf_rdy,
    output app_rd_data, app_rd_data_valid,
    output app_rd_data_end,
    output init_calib_complete, cmd_error
  );
endinterface

// File: rtl/mig_ui_responder_sync_fifo.sv
// sync_fifo: single-clock FIFO with registered full/empty flags.
// Caller must not push when full nor pop when empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q;
  logic [AW-1:0]    rd_q;
  logic [AW:0]      cnt_q;
  logic [AW:0]      cnt_d;
  logic             full_q;
  logic             empty_q;

  assign cnt_d = cnt_q + (AW+1)'(push_i)
               - (AW+1)'(pop_i);

  // Pointers, occupancy and flags computed from next count
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      if (push_i) wr_q <= wr_q + AW'(1);
      if (pop_i)  rd_q <= rd_q + AW'(1);
      cnt_q   <= cnt_d;
      full_q  <= (cnt_d == (AW+1)'(DEPTH));
      empty_q <= (cnt_d == '0);
    end
  end

  // Storage array, no reset needed
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_q] <= din_i;
  end

  assign dout_o  = mem_q[rd_q];
  assign full_o  = full_q;
  assign empty_o = empty_q;

endmodule

// File: rtl/mig_ui_responder.sv
// mig_ui_responder: BRAM-backed stand-in for MIG 7-series + DDR3.
// Optional MIG_UI_STALL_EN adds LFSR-driven ready backpressure.
module mig_ui_responder
  import mig_ui_pkg::*;
#(
  parameter int ADDR_WIDTH     = 28,
  parameter int APP_DATA_WIDTH = 128,
  parameter int MASK_WIDTH     = 16,
  parameter int MEM_DEPTH_LOG2 = 10,
  parameter int CMD_FIFO_DEPTH = 4,
  parameter int WDF_FIFO_DEPTH = 4,
  parameter int RD_LATENCY     = 4,
  parameter int CALIB_CYCLES   = 16
) (
  input logic               ui_clk,
  input logic               ui_clk_sync_rst,
  mig_ui_responder_if.slave app
);
  localparam int CW = $clog2(CALIB_CYCLES + 1);
  localparam int EW = $bits(cmd_entry_t);
  localparam int WW = APP_DATA_WIDTH + MASK_WIDTH;
  localparam int DW = APP_DATA_WIDTH;

  logic [CW-1:0]             cal_cnt_q;
  logic                      calib_q;
  logic                      err_q;
  logic                      stall;
  logic                      cmd_full;
  logic                      cmd_empty;
  logic                      wdf_full;
  logic                      wdf_empty;
  logic                      cmd_acc;
  logic                      cmd_push;
  logic                      wdf_push;
  logic                      exec_rd;
  logic                      exec_wr;
  cmd_entry_t                ent_d;
  cmd_entry_t                head;
  logic [EW-1:0]             head_raw;
  logic [WW-1:0]             wdf_head;
  logic [DW-1:0]             wdata;
  logic [MASK_WIDTH-1:0]     wmask;
  logic [MEM_DEPTH_LOG2-1:0] idx;
  logic [DW-1:0]             mem [2**MEM_DEPTH_LOG2];
  logic [DW-1:0]             bram_q;
  logic                      bram_vld_q;
  logic [RD_LATENCY-1:0]     vld_q;
  logic [DW-1:0]             dat_q [RD_LATENCY];
  logic                      unused_bits;

  // Calibration emulation: count out CALIB_CYCLES then hold
  always_ff @(posedge ui_clk) begin
    if (ui_clk_sync_rst) begin
      cal_cnt_q <= '0;
      calib_q   <= 1'b0;
    end else if (!calib_q) begin
      cal_cnt_q <= cal_cnt_q + CW'(1);
      calib_q   <= (cal_cnt_q == CW'(CALIB_CYCLES - 1));
    end
  end

`ifdef MIG_UI_STALL_EN
  logic [7:0] lfsr_q;

  // Refresh/backpressure emulation
  always_ff @(posedge ui_clk) begin
    if (ui_clk_sync_rst) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= {lfsr_q[6:0], ^(lfsr_q & LFSR_TAPS)};
    end
  end

  assign stall = (lfsr_q[1:0] == 2'b00);
`else
  assign stall = 1'b0;
`endif

  assign app.app_rdy     = calib_q && !cmd_full && !stall;
  assign app.app_wdf_rdy = calib_q && !wdf_full && !stall;

  assign cmd_acc  = app.app_en && app.app_rdy;
  assign cmd_push = cmd_acc && is_legal(app.app_cmd);
  assign wdf_push = app.app_wdf_wren && app.app_wdf_rdy;

  // Queue entry built from the incoming command
  always_comb begin
    ent_d     = '0;
    ent_d.idx = IDX_MAX_W'(app.app_addr[3 +: MEM_DEPTH_LOG2]);
    ent_d.cmd = mig_cmd_e'(app.app_cmd);
  end

  // Sticky illegal-command flag
  always_ff @(posedge ui_clk) begin
    if (ui_clk_sync_rst) begin
      err_q <= 1'b0;
    end else if (cmd_acc && !is_legal(app.app_cmd)) begin
      err_q <= 1'b1;
    end
  end

  sync_fifo #(.WIDTH(EW), .DEPTH(CMD_FIFO_DEPTH)) u_cmd_fifo (
    .clk     (ui_clk),
    .rst     (ui_clk_sync_rst),
    .push_i  (cmd_push),
    .din_i   (ent_d),
    .pop_i   (exec_rd || exec_wr),
    .dout_o  (head_raw),
    .full_o  (cmd_full),
    .empty_o (cmd_empty)
  );

  sync_fifo #(.WIDTH(WW), .DEPTH(WDF_FIFO_DEPTH)) u_wdf_fifo (
    .clk     (ui_clk),
    .rst     (ui_clk_sync_rst),
    .push_i  (wdf_push),
    .din_i   ({app.app_wdf_data, app.app_wdf_mask}),
    .pop_i   (exec_wr),
    .dout_o  (wdf_head),
    .full_o  (wdf_full),
    .empty_o (wdf_empty)
  );

  assign head           = cmd_entry_t'(head_raw);
  assign {wdata, wmask} = wdf_head;
  assign idx            = head.idx[MEM_DEPTH_LOG2-1:0];

  assign exec_rd = !ui_clk_sync_rst && !cmd_empty
                && (head.cmd == CMD_READ);
  assign exec_wr = !ui_clk_sync_rst && !cmd_empty
                && (head.cmd == CMD_WRITE) && !wdf_empty;

  // BRAM: byte-masked write port, registered read port
  always_ff @(posedge ui_clk) begin
    if (exec_wr) begin
      for (int b = 0; b < MASK_WIDTH; b++) begin
        if (!wmask[b]) mem[idx][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
    if (exec_rd) bram_q <= mem[idx];
  end

  // Read return pipe; reset drops in-flight reads
  always_ff @(posedge ui_clk) begin
    if (ui_clk_sync_rst) begin
      bram_vld_q <= 1'b0;
      vld_q      <= '0;
      for (int i = 0; i < RD_LATENCY; i++) dat_q[i] <= '0;
    end else begin
      bram_vld_q <= exec_rd;
      vld_q[0]   <= bram_vld_q;
      dat_q[0]   <= bram_q;
      for (int i = 1; i < RD_LATENCY; i++) begin
        vld_q[i] <= vld_q[i-1];
        dat_q[i] <= dat_q[i-1];
      end
    end
  end

  assign app.app_rd_data         = dat_q[RD_LATENCY-1];
  assign app.app_rd_data_valid   = vld_q[RD_LATENCY-1];
  assign app.app_rd_data_end     = vld_q[RD_LATENCY-1];
  assign app.init_calib_complete = calib_q;
  assign app.cmd_error           = err_q;

  assign unused_bits = ^{app.app_addr, app.app_wdf_end, head.idx};

endmodule

// File: tb/tb_mig_ui_responder.sv
// tb_mig_ui_responder: directed scoreboard bench for mig_ui_responder.
// Expected read data queued at stimulus time, checked on return.
module tb_mig_ui_responder;
  import mig_ui_pkg::*;

  localparam int AWD = 28;
  localparam int DW  = 128;
  localparam int MW  = 16;
  localparam logic [2:0] WR = 3'b000;
  localparam logic [2:0] RD = 3'b001;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   compared = 0;
  int   mismatched = 0;
  int   cyc = 0;
  logic [DW-1:0] exp_q [$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  mig_ui_responder_if #(
    .ADDR_WIDTH(AWD), .APP_DATA_WIDTH(DW), .MASK_WIDTH(MW)
  ) ifc ();

  mig_ui_responder #(
    .ADDR_WIDTH(AWD), .APP_DATA_WIDTH(DW), .MASK_WIDTH(MW),
    .MEM_DEPTH_LOG2(10), .CMD_FIFO_DEPTH(4), .WDF_FIFO_DEPTH(4),
    .RD_LATENCY(4), .CALIB_CYCLES(16)
  ) dut (
    .ui_clk          (clk),
    .ui_clk_sync_rst (rst),
    .app             (ifc.slave)
  );

  task automatic chk(input string tag,
                     input logic [DW-1:0] obs,
                     input logic [DW-1:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (ifc.app_rd_data_valid === 1'b1) begin
      chk("rd_outstanding", DW'(exp_q.size() > 0), DW'(1));
      chk("rd_end", DW'(ifc.app_rd_data_end), DW'(1));
      if (exp_q.size() > 0) chk("rd_data", ifc.app_rd_data, exp_q.pop_front());
    end
  end

  task automatic send_cmd(input logic [2:0] c,
                          input logic [AWD-1:0] a,
                          output int t);
    int n = 0;
    @(negedge clk);
    ifc.app_en = 1'b1; ifc.app_cmd = c; ifc.app_addr = a;
    while (ifc.app_rdy !== 1'b1 && n < 200) begin
      @(negedge clk); n++;
    end
    chk("cmd_timeout", DW'(n < 200), DW'(1));
    @(posedge clk); #1;
    t = cyc;
    ifc.app_en = 1'b0;
  endtask

  task automatic send_wd(input logic [DW-1:0] d,
                         input logic [MW-1:0] m);
    int n = 0;
    @(negedge clk);
    ifc.app_wdf_wren = 1'b1; ifc.app_wdf_end = 1'b1;
    ifc.app_wdf_data = d; ifc.app_wdf_mask = m;
    while (ifc.app_wdf_rdy !== 1'b1 && n < 200) begin
      @(negedge clk); n++;
    end
    chk("wdf_timeout", DW'(n < 200), DW'(1));
    @(posedge clk); #1;
    ifc.app_wdf_wren = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk); n++;
    end
    chk("drain", DW'(exp_q.size()), DW'(0));
  endtask

  initial begin
    int t;
    int n;
    int nv;
    logic [DW-1:0] d2;
    logic [DW-1:0] va;
    logic [DW-1:0] vb;
    logic [DW-1:0] v5 [5];

    ifc.app_en = 1'b0; ifc.app_cmd = 3'b000; ifc.app_addr = '0;
    ifc.app_wdf_wren = 1'b0; ifc.app_wdf_end = 1'b0;
    ifc.app_wdf_data = '0; ifc.app_wdf_mask = '0;

    // 1: calibration window
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i <= 16; i++) begin
      @(negedge clk);
      chk("calib", DW'(ifc.init_calib_complete), DW'(i == 16));
      chk("app_rdy", DW'(ifc.app_rdy), DW'(i == 16));
      chk("wdf_rdy", DW'(ifc.app_wdf_rdy), DW'(i == 16));
      chk("cmd_err0", DW'(ifc.cmd_error), DW'(0));
    end

    // 2: write/read word 0, latency and single pulse
    d2 = 128'h55AA_0123_4567_89AB_FEDC_BA98_7654_3210;
    send_cmd(WR, 28'd0, t);
    send_wd(d2, '0);
    repeat (3) @(posedge clk);
    exp_q.push_back(d2);
    send_cmd(RD, 28'd0, t);
    n = 0;
    while (ifc.app_rd_data_valid !== 1'b1 && n < 20) begin
      @(negedge clk); n++;
    end
    chk("rd_latency", DW'(cyc - t), DW'(5));
    @(negedge clk);
    chk("single_pulse", DW'(ifc.app_rd_data_valid), DW'(0));
    drain();

    // 3: byte mask merge on word 1
    send_cmd(WR, 28'd8, t);
    send_wd({DW{1'b1}}, '0);
    send_cmd(WR, 28'd8, t);
    send_wd('0, 16'h00FF);
    exp_q.push_back({64'h0, 64'hFFFF_FFFF_FFFF_FFFF});
    send_cmd(RD, 28'd8, t);
    exp_q.push_back({64'h0, 64'hFFFF_FFFF_FFFF_FFFF});
    send_cmd(RD, 28'h000_200D, t);
    drain();

    // 4: data before command, command before data
    va = {4{32'hA1B2_C3D4}};
    vb = {4{32'h0F1E_2D3C}};
    send_wd(va, '0);
    repeat (2) @(posedge clk);
    send_cmd(WR, 28'd16, t);
    send_cmd(WR, 28'd24, t);
    repeat (3) @(posedge clk);
    send_wd(vb, '0);
    exp_q.push_back(va);
    exp_q.push_back(vb);
    send_cmd(RD, 28'd16, t);
    send_cmd(RD, 28'd24, t);
    drain();

    // 5: queue fills while data withheld
    for (int i = 0; i < 5; i++) v5[i] = {4{32'hC0DE_0000 + 32'(i)}};
    for (int i = 0; i < 4; i++) send_cmd(WR, 28'(32 + 8*i), t);
    repeat (3) begin
      @(negedge clk);
      chk("full_rdy", DW'(ifc.app_rdy), DW'(0));
    end
    fork
      send_cmd(WR, 28'd64, t);
      for (int i = 0; i < 5; i++) send_wd(v5[i], '0);
    join
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(v5[i]);
      send_cmd(RD, 28'(32 + 8*i), t);
    end
    drain();

    // 6: illegal command, then reset with read in flight
    send_cmd(3'b010, 28'd0, t);
    nv = 0;
    repeat (10) begin
      @(negedge clk);
      if (ifc.app_rd_data_valid === 1'b1) nv++;
    end
    chk("cmd_err1", DW'(ifc.cmd_error), DW'(1));
    chk("illegal_no_rd", DW'(nv), DW'(0));
    send_cmd(RD, 28'd0, t);
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_calib", DW'(ifc.init_calib_complete), DW'(0));
    chk("rst_err", DW'(ifc.cmd_error), DW'(0));
    nv = 0;
    repeat (12) begin
      @(negedge clk);
      if (ifc.app_rd_data_valid === 1'b1) nv++;
    end
    chk("rst_drop", DW'(nv), DW'(0));

    // BRAM survives reset
    exp_q.push_back(d2);
    send_cmd(RD, 28'd0, t);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
